// File: rtl/pio_gpio_bidir_pkg.sv
// Shared constants for the bidirectional GPIO port: register offsets, edge
// selection codes and the warm-up counter sizing helper.
package pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
    localparam logic [2:0] PIO_ADDR_DIR      = 3'd1;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR   = 3'd5;

    localparam int PIO_EDGE_RISE = 0;
    localparam int PIO_EDGE_FALL = 1;
    localparam int PIO_EDGE_ANY  = 2;

    // Counter must reach SYNC_STAGES+1 and hold there.
    function automatic int pio_wu_width(input int sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage

// File: rtl/pio_gpio_bidir_sync_edge.sv
// Input synchroniser, previous-value flop and edge detector with a post-reset
// warm-up window that masks edges produced by the all-zero reset state.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = PIO_EDGE_ANY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] sync_val_o,
    output logic [WIDTH-1:0] edge_pulse_o
);

    localparam int              WU_W    = pio_wu_width(SYNC_STAGES);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  raw_edge;
    logic [WU_W-1:0]                   wu_q, wu_d;

    assign wu_d = (wu_q == WU_DONE) ? wu_q : wu_q + WU_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            wu_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            wu_q   <= wu_d;
        end
    end

    assign sync_val_o = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_edge
        if (EDGE_TYPE == PIO_EDGE_RISE) begin : g_rise
            assign raw_edge[i] = sync_q[SYNC_STAGES-1][i] & ~prev_q[i];
        end else if (EDGE_TYPE == PIO_EDGE_FALL) begin : g_fall
            assign raw_edge[i] = ~sync_q[SYNC_STAGES-1][i] & prev_q[i];
        end else begin : g_any
            assign raw_edge[i] = sync_q[SYNC_STAGES-1][i] ^ prev_q[i];
        end
    end

    assign edge_pulse_o = (wu_q == WU_DONE) ? raw_edge : '0;

endmodule

// File: rtl/pio_gpio_bidir.sv
// Avalon-MM GPIO port: per-bit direction, atomic set/clear, edge capture, IRQ.
// Define PIO_OPEN_DRAIN_EN for open-drain pins (oe only while driving a 0).
module pio_gpio_bidir
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = PIO_EDGE_ANY,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] sync_val, edge_pulse;
    logic [WIDTH-1:0] wd, rd_w;
    logic             wr;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .pad_i        (pad_in),
        .sync_val_o   (sync_val),
        .edge_pulse_o (edge_pulse)
    );

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr) begin
            case (address)
                PIO_ADDR_DATA:     data_d  = wd;
                PIO_ADDR_DIR:      dir_d   = wd;
                PIO_ADDR_IRQ_MASK: mask_d  = wd;
                PIO_ADDR_EDGE_CAP: cap_clr = wd;
                PIO_ADDR_OUTSET:   data_d  = data_q | wd;
                PIO_ADDR_OUTCLR:   data_d  = data_q & ~wd;
                default: ;
            endcase
        end
        // A fresh edge overrides a same-cycle write-1-clear.
        cap_d = (cap_q & ~cap_clr) | edge_pulse;
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            dir_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        rd_w = '0;
        case (address)
            PIO_ADDR_DATA:     rd_w = sync_val;
            PIO_ADDR_DIR:      rd_w = dir_q;
            PIO_ADDR_IRQ_MASK: rd_w = mask_q;
            PIO_ADDR_EDGE_CAP: rd_w = cap_q;
            default:           rd_w = '0;
        endcase
    end

    assign readdata = 32'(rd_w);
    assign out_port = data_q;
    assign irq      = irq_q;

`ifdef PIO_OPEN_DRAIN_EN
    assign pad_oe = dir_q & ~data_q;
`else
    assign pad_oe = dir_q;
`endif

endmodule
